// File: rtl/plab3_mem_blocking_cache_simple_ctrl.sv
// Control FSM for the simple blocking cache datapath: one transaction in flight,
// sequencing cache request -> memory request -> memory response -> cache response,
// with optional constant-latency padding of the response.
module plab3_mem_blocking_cache_simple_ctrl #(
  parameter int unsigned PAD_CYCLES = 16,
  parameter int unsigned CNT_NBITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cachereq_val,
  output logic cachereq_rdy,
  output logic cacheresp_val,
  input  logic cacheresp_rdy,
  output logic memreq_val,
  input  logic memreq_rdy,
  input  logic memresp_val,
  output logic memresp_rdy,
  input  logic pad_en,
  output logic cachereq_reg_en,
  output logic memresp_reg_en,
  output logic busy,
  output logic pad_overrun
);

  localparam int unsigned SUM_W = CNT_NBITS + 1;
  localparam logic [SUM_W-1:0] PAD_LIM = SUM_W'(PAD_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEMREQ  = 3'd1,
    MEMWAIT = 3'd2,
    PAD     = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CNT_NBITS-1:0] cnt;
  logic [CNT_NBITS-1:0] cnt_sat;
  logic [SUM_W-1:0]     cnt_inc;
  logic                 pad_q;
  logic                 overrun_q;

  // Moore handshake flags, registered alongside the state they decode
  logic                 creq_rdy_q;
  logic                 cresp_val_q;
  logic                 mreq_val_q;
  logic                 mresp_rdy_q;
  logic                 busy_q;

  // Wide sum so cnt+1 compares correctly even when cnt is saturated
  assign cnt_inc = {1'b0, cnt} + SUM_W'(1);
  assign cnt_sat = (&cnt) ? cnt : cnt + CNT_NBITS'(1);

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cachereq_val) state_nx = MEMREQ;
      end
      MEMREQ: begin
        if (memreq_rdy) state_nx = MEMWAIT;
      end
      MEMWAIT: begin
        if (memresp_val) begin
          if (pad_q && (cnt_inc < PAD_LIM)) state_nx = PAD;
          else                              state_nx = RESP;
        end
      end
      PAD: begin
        if (cnt_inc == PAD_LIM) state_nx = RESP;
      end
      RESP: begin
        if (cacheresp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latency counter, pad mode, sticky overrun flag and output flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pad_q       <= 1'b0;
      overrun_q   <= 1'b0;
      creq_rdy_q  <= 1'b1;
      cresp_val_q <= 1'b0;
      mreq_val_q  <= 1'b0;
      mresp_rdy_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state <= state_nx;

      case (state)
        IDLE: begin
          if (cachereq_val) begin
            cnt   <= CNT_NBITS'(1);
            pad_q <= pad_en;
          end
        end
        default: cnt <= cnt_sat;
      endcase

      if ((state == MEMWAIT) && memresp_val && pad_q && (cnt_inc > PAD_LIM))
        overrun_q <= 1'b1;

      creq_rdy_q  <= (state_nx == IDLE);
      mreq_val_q  <= (state_nx == MEMREQ);
      mresp_rdy_q <= (state_nx == MEMWAIT);
      cresp_val_q <= (state_nx == RESP);
      busy_q      <= (state_nx != IDLE);
    end
  end

  // Outputs forced low while reset is held, even before the first reset edge
  assign cachereq_rdy    = creq_rdy_q  & ~reset;
  assign memreq_val      = mreq_val_q  & ~reset;
  assign memresp_rdy     = mresp_rdy_q & ~reset;
  assign cacheresp_val   = cresp_val_q & ~reset;
  assign busy            = busy_q      & ~reset;
  assign pad_overrun     = overrun_q   & ~reset;

  // Datapath register loads coincide with the handshakes they capture
  assign cachereq_reg_en = cachereq_rdy & cachereq_val;
  assign memresp_reg_en  = memresp_rdy  & memresp_val;

endmodule

// File: tb/tb_plab3_mem_blocking_cache_simple_ctrl.sv
// Scoreboard bench: transactions push their expected response timing into a
// queue; an independent monitor checks every cache response as it appears.
module tb_plab3_mem_blocking_cache_simple_ctrl;

  logic clk;
  logic reset;
  logic cachereq_val, cachereq_rdy;
  logic cacheresp_val, cacheresp_rdy;
  logic memreq_val, memreq_rdy;
  logic memresp_val, memresp_rdy;
  logic pad_en;
  logic cachereq_reg_en, memresp_reg_en;
  logic busy, pad_overrun;

  plab3_mem_blocking_cache_simple_ctrl #(.PAD_CYCLES(16), .CNT_NBITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cachereq_val   (cachereq_val),
    .cachereq_rdy   (cachereq_rdy),
    .cacheresp_val  (cacheresp_val),
    .cacheresp_rdy  (cacheresp_rdy),
    .memreq_val     (memreq_val),
    .memreq_rdy     (memreq_rdy),
    .memresp_val    (memresp_val),
    .memresp_rdy    (memresp_rdy),
    .pad_en         (pad_en),
    .cachereq_reg_en(cachereq_reg_en),
    .memresp_reg_en (memresp_reg_en),
    .busy           (busy),
    .pad_overrun    (pad_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int first;
    int hold;
    bit ovf;
  } exp_t;
  exp_t q[$];

  // Directed vector: input release cycles (relative to acceptance) and hand-computed response
  typedef struct {
    bit pad;
    bit tog;
    bit keep;
    int mrq_from;
    int mrs_from;
    int crs_from;
    int first;
    int hold;
    bit ovf;
  } vec_t;

  // Monitor: pops an expectation at each new response and checks its timing
  bit   in_resp = 0;
  int   hold_n  = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 0;
    end else begin
      if (cacheresp_val && !in_resp) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp cyc=%0d: got cacheresp_val=1 want 0", cyc);
        end else begin
          cur = q.pop_front();
          chk("resp_first_cycle", cyc, cur.first);
          chk("pad_overrun_at_resp", 32'(pad_overrun), 32'(cur.ovf));
          in_resp = 1;
          hold_n  = 0;
        end
      end
      if (in_resp) begin
        if (cacheresp_val) begin
          hold_n++;
          if (cacheresp_rdy) begin
            chk("resp_hold_cycles", hold_n, cur.hold);
            in_resp = 0;
          end
        end else begin
          chk("resp_held", 32'(cacheresp_val), 32'd1);
          in_resp = 0;
        end
      end
    end
  end

  task automatic drive(input vec_t v, input int k, input int hs);
    cachereq_val  = (k == 0) || (v.keep && k <= hs);
    pad_en        = (v.tog && k[0]) ? ~v.pad : v.pad;
    memreq_rdy    = (k >= v.mrq_from);
    memresp_val   = (k >= v.mrs_from);
    cacheresp_rdy = (k >= v.crs_from);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (cachereq_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_idle", 32'(cachereq_rdy), 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    int  hs, mrq_hs, mrs_hs, t0, ncq, nmr;
    bit  ok;
    exp_t e;
    hs     = v.first + v.hold - 1;
    mrq_hs = (v.mrq_from > 1) ? v.mrq_from : 1;
    mrs_hs = (v.mrs_from > mrq_hs + 1) ? v.mrs_from : mrq_hs + 1;
    ncq = 0;
    nmr = 0;
    wait_idle(ok);
    if (!ok) return;
    t0 = cyc;
    e.first = t0 + v.first;
    e.hold  = v.hold;
    e.ovf   = v.ovf;
    q.push_back(e);
    for (int k = 0; k <= hs + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      drive(v, k, hs);
      @(negedge clk);
      ncq += int'(cachereq_reg_en);
      nmr += int'(memresp_reg_en);
      if (k >= 1) begin
        chk("cachereq_rdy", 32'(cachereq_rdy), 32'(k > hs));
        chk("busy", 32'(busy), 32'(k <= hs));
        chk("memreq_val", 32'(memreq_val), 32'(k <= mrq_hs));
        chk("memresp_rdy", 32'(memresp_rdy), 32'(k > mrq_hs && k <= mrs_hs));
      end
    end
    chk("cachereq_reg_en_pulses", ncq, 1);
    chk("memresp_reg_en_pulses", nmr, 1);
    @(posedge clk);
    #1;
    cachereq_val = 0;
  endtask

  task automatic all_zero(input string name);
    chk(name, {23'd0, cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy,
               cachereq_reg_en, memresp_reg_en, busy, pad_overrun}, 32'd0);
  endtask

  task automatic run_abort(input vec_t v, input int rk);
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    for (int k = 0; k <= rk + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k <= rk) drive(v, k, 1000);
      else begin
        cachereq_val  = 0;
        memreq_rdy    = 0;
        memresp_val   = 0;
        cacheresp_rdy = 1;
      end
      reset = (k == rk);
      @(negedge clk);
      if (k >= 1 && k < rk) begin
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_no_resp", 32'(cacheresp_val), 32'd0);
      end else if (k == rk) begin
        all_zero("abort_outputs_in_reset");
      end else if (k > rk) begin
        chk("abort_idle_rdy", 32'(cachereq_rdy), 32'd1);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_resp_after", 32'(cacheresp_val), 32'd0);
        chk("abort_overrun_clr", 32'(pad_overrun), 32'd0);
      end
    end
  endtask

  // Expected first-response cycle and hold length worked out by hand from the
  // release cycles (acceptance = cycle 0, PAD_CYCLES = 16)
  vec_t vecs[10];
  initial begin
    //          pad tog keep mrq mrs crs first hold ovf
    vecs[0] = '{0, 0, 0, 0,  0,  0,  3,  1, 0};  // plain hit-path timing
    vecs[1] = '{1, 0, 0, 0,  0,  0,  16, 1, 0};  // padded to 16
    vecs[2] = '{1, 0, 0, 0,  14, 0,  16, 1, 0};  // natural 15, one PAD cycle
    vecs[3] = '{1, 0, 0, 0,  15, 0,  16, 1, 0};  // natural == 16, no overrun
    vecs[4] = '{0, 1, 0, 0,  0,  0,  3,  1, 0};  // pad_en toggled, unpadded
    vecs[5] = '{1, 1, 0, 0,  0,  0,  16, 1, 0};  // pad_en toggled, padded
    vecs[6] = '{1, 0, 0, 0,  22, 0,  23, 1, 1};  // natural 23 overruns
    vecs[7] = '{0, 0, 1, 6,  0,  12, 8,  5, 1};  // backpressure, sticky overrun
    vecs[8] = '{1, 0, 0, 0,  0,  20, 16, 5, 1};  // resp stall while padded
    vecs[9] = '{1, 0, 0, 0,  16, 0,  17, 1, 1};  // natural 17 overruns
  end

  vec_t ab_memwait, ab_pad;

  initial begin
    reset         = 1;
    cachereq_val  = 0;
    cacheresp_rdy = 0;
    memreq_rdy    = 0;
    memresp_val   = 0;
    pad_en        = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      all_zero("outputs_in_reset");
    end
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("post_reset_rdy", 32'(cachereq_rdy), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    ab_memwait = '{0, 1, 1, 1, 1000, 0, 0, 0, 0};
    run_abort(ab_memwait, 4);
    ab_pad     = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    run_abort(ab_pad, 6);

    run_txn(vecs[0]);
    run_txn(vecs[3]);
    run_txn(vecs[9]);
    run_txn(vecs[8]);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d: got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
